// File: rtl/prm_chk_pkg.sv
// prm_chk_pkg: shared FSM encoding, checker code width and index/count widths for the edge sweep
package prm_chk_pkg;

    localparam int CODE_W  = 15;
    localparam int IDX_W   = 11;
    localparam int CNT_W   = 12;
    localparam int WADDR_W = 6;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EVAL, EMIT, DONE} sweep_state_t;

    function automatic int bit_w(input int w);
        return w > 1 ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/prm_mask_packer.sv
// prm_mask_packer: packs per-edge mask bits into a result word and counts blocked edges
module prm_mask_packer
    import prm_chk_pkg::*;
#(
    parameter int WORD_W = 32,
    localparam int BIT_W = bit_w(WORD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_all,
    input  logic              clr_word,
    input  logic              wr,
    input  logic [BIT_W-1:0]  bit_idx,
    input  logic              mask,
    output logic [WORD_W-1:0] word,
    output logic [CNT_W-1:0]  blocked_cnt
);

    // word buffer and blocked count: full clear at sweep start, word clear after each handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word        <= '0;
            blocked_cnt <= '0;
        end else if (clr_all) begin
            word        <= '0;
            blocked_cnt <= '0;
        end else begin
            if (clr_word)
                word <= '0;
            else if (wr)
                word[bit_idx] <= mask;
            if (wr && mask)
                blocked_cnt <= blocked_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prm_edge_sweep_ctrl.sv
// prm_edge_sweep_ctrl: walks the edge table through an external obstacle checker and emits packed mask words
module prm_edge_sweep_ctrl
    import prm_chk_pkg::*;
#(
    parameter int N_EDGES = 1024,
    parameter int WORD_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               tbl_rd,
    output logic [IDX_W-1:0]   tbl_addr,
    input  logic [CODE_W-1:0]  tbl_data,
    output logic [CODE_W-1:0]  chk_code,
    input  logic               chk_mask,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WORD_W-1:0]  res_data,
    output logic [WADDR_W-1:0] res_addr,
    output logic [CNT_W-1:0]   blocked_cnt
);

    localparam int BIT_W = bit_w(WORD_W);
    localparam logic [IDX_W-1:0] LAST_EDGE = IDX_W'(N_EDGES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);

    sweep_state_t     state;
    logic [BIT_W-1:0] bit_idx;
    logic             last_edge, word_full, go, pk_wr, pk_clr_word;

    // tbl_addr doubles as the edge index, so the last-edge test reads it directly
    assign last_edge   = tbl_addr == LAST_EDGE;
    assign word_full   = bit_idx == LAST_BIT;
    assign go          = state == IDLE && start && !abort;
    assign pk_wr       = state == EVAL && !abort;
    assign pk_clr_word = state == EMIT && res_ready && !abort;

    prm_mask_packer #(.WORD_W(WORD_W)) u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_all     (go),
        .clr_word    (pk_clr_word),
        .wr          (pk_wr),
        .bit_idx     (bit_idx),
        .mask        (chk_mask),
        .word        (res_data),
        .blocked_cnt (blocked_cnt)
    );

    // sweep FSM with registered strobes; abort outranks every transition out of a busy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            tbl_rd    <= 1'b0;
            tbl_addr  <= '0;
            chk_code  <= '0;
            res_valid <= 1'b0;
            res_addr  <= '0;
            bit_idx   <= '0;
        end else begin
            done   <= 1'b0;
            tbl_rd <= 1'b0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                res_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        tbl_rd   <= 1'b1;
                        tbl_addr <= '0;
                        bit_idx  <= '0;
                        res_addr <= '0;
                    end
                    FETCH: state <= LOAD;
                    LOAD: begin
                        chk_code <= tbl_data;
                        state    <= EVAL;
                    end
                    EVAL: if (word_full || last_edge) begin
                        state     <= EMIT;
                        res_valid <= 1'b1;
                    end else begin
                        state    <= FETCH;
                        tbl_rd   <= 1'b1;
                        tbl_addr <= tbl_addr + IDX_W'(1);
                        bit_idx  <= bit_idx + BIT_W'(1);
                    end
                    EMIT: if (res_ready) begin
                        res_valid <= 1'b0;
                        if (last_edge) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= FETCH;
                            tbl_rd   <= 1'b1;
                            tbl_addr <= tbl_addr + IDX_W'(1);
                            bit_idx  <= '0;
                            res_addr <= res_addr + WADDR_W'(1);
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_sweep_ctrl.sv
// tb_prm_edge_sweep_ctrl: directed scoreboard bench over three sweep lengths with a model obstacle checker
module tb_prm_edge_sweep_ctrl;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start[3], abort[3], res_ready[3];
    logic        busy[3], done[3], tbl_rd[3], res_valid[3], chk_mask[3];
    logic [10:0] tbl_addr[3];
    logic [14:0] tbl_data[3], chk_code[3];
    logic [31:0] res_data[3];
    logic [5:0]  res_addr[3];
    logic [11:0] blocked_cnt[3];

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    function automatic logic [14:0] tbl_code(input int g, input int a);
        return (g == 2 || (g == 0 && a == 1)) ? 15'h0000 : 15'h3620;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NE = (g == 0) ? 3 : (g == 1) ? 64 : 33;
        prm_edge_sweep_ctrl #(.N_EDGES(NE), .WORD_W(32)) dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .abort       (abort[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .tbl_rd      (tbl_rd[g]),
            .tbl_addr    (tbl_addr[g]),
            .tbl_data    (tbl_data[g]),
            .chk_code    (chk_code[g]),
            .chk_mask    (chk_mask[g]),
            .res_valid   (res_valid[g]),
            .res_ready   (res_ready[g]),
            .res_data    (res_data[g]),
            .res_addr    (res_addr[g]),
            .blocked_cnt (blocked_cnt[g])
        );
        assign chk_mask[g] = chk_code[g] == 15'h3620;
        always @(posedge clk) if (tbl_rd[g]) tbl_data[g] <= tbl_code(g, int'(tbl_addr[g]));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int g, input int ne);
        for (int w = 0; w < (ne + 31) / 32; w++) begin
            logic [31:0] d = '0;
            for (int b = 0; b < 32; b++)
                if (w * 32 + b < ne) d[b] = tbl_code(g, w * 32 + b) == 15'h3620;
            sb.push_back('{addr: 6'(w), data: d});
        end
    endtask

    task automatic run_sweep(input int g, input int stall, output int done_cyc);
        int  cycles = 1;
        int  held = 0;
        bit  fin = 0;
        done_cyc = 0;
        @(negedge clk) start[g] = 1'b1;
        @(negedge clk) start[g] = 1'b0;
        chk("busy_after_start", busy[g], 1);
        while (!fin && cycles < 3000) begin
            if (res_valid[g] && sb.size() == 0) begin
                chk("unexpected_word", res_valid[g], 0);
                fin = 1;
            end else if (res_valid[g] && held < stall) begin
                chk("stall_data", res_data[g], sb[0].data);
                chk("stall_addr", res_addr[g], sb[0].addr);
                held++;
            end else if (res_valid[g]) begin
                res_ready[g] = 1'b1;
                chk("word_data", res_data[g], sb[0].data);
                chk("word_addr", res_addr[g], sb[0].addr);
                void'(sb.pop_front());
                held = 0;
                @(negedge clk);
                cycles++;
                res_ready[g] = 1'b0;
                if (sb.size() == 0) begin
                    chk("done_after_handshake", done[g], 1);
                    chk("busy_at_done", busy[g], 0);
                    done_cyc = cycles - 1;
                    @(negedge clk);
                    chk("done_one_cycle", done[g], 0);
                    fin = 1;
                end
            end
            if (!fin) begin
                @(negedge clk);
                cycles++;
            end
        end
        if (!fin) chk("sweep_timeout", 0, 1);
    endtask

    initial begin
        int dc, fetches, seen;
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            abort[g] = 1'b0;
            res_ready[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_busy", busy[g], 0);
            chk("rst_done", done[g], 0);
            chk("rst_tbl_rd", tbl_rd[g], 0);
            chk("rst_tbl_addr", tbl_addr[g], 0);
            chk("rst_chk_code", chk_code[g], 0);
            chk("rst_res_valid", res_valid[g], 0);
            chk("rst_res_data", res_data[g], 0);
            chk("rst_res_addr", res_addr[g], 0);
            chk("rst_blocked_cnt", blocked_cnt[g], 0);
        end
        rst = 1'b0;

        push_exp(0, 3);
        run_sweep(0, 0, dc);
        chk("n3_blocked_cnt", blocked_cnt[0], 2);
        chk("n3_chk_code_held", chk_code[0], 15'h3620);
        repeat (3) @(negedge clk);
        chk("n3_blocked_cnt_holds", blocked_cnt[0], 2);

        push_exp(1, 64);
        run_sweep(1, 10, dc);
        chk("n64_blocked_cnt", blocked_cnt[1], 64);

        push_exp(2, 33);
        run_sweep(2, 0, dc);
        chk("n33_blocked_cnt", blocked_cnt[2], 0);
        chk("n33_min_cycles", dc >= 101, 1);

        @(negedge clk) start[1] = 1'b1;
        @(negedge clk) start[1] = 1'b0;
        fetches = 0;
        for (int c = 0; c < 200 && fetches < 5; c++) begin
            if (tbl_rd[1]) fetches++;
            if (fetches < 5) @(negedge clk);
        end
        chk("abort_fetch5_reached", fetches, 5);
        abort[1] = 1'b1;
        @(negedge clk) abort[1] = 1'b0;
        chk("abort_busy", busy[1], 0);
        chk("abort_tbl_rd", tbl_rd[1], 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            seen |= int'(res_valid[1]) | int'(done[1]) | int'(tbl_rd[1]);
            @(negedge clk);
        end
        chk("abort_quiet", seen, 0);
        push_exp(1, 64);
        run_sweep(1, 0, dc);
        chk("restart_blocked_cnt", blocked_cnt[1], 64);

        @(negedge clk) start[1] = 1'b1;
        @(negedge clk) start[1] = 1'b0;
        for (int c = 0; c < 200 && !res_valid[1]; c++) @(negedge clk);
        chk("emit_reached", res_valid[1], 1);
        chk("emit_blocked_cnt", blocked_cnt[1], 32);
        rst = 1'b1;
        #1;
        chk("rst_async_res_valid", res_valid[1], 0);
        chk("rst_async_busy", busy[1], 0);
        chk("rst_async_blocked_cnt", blocked_cnt[1], 0);
        @(negedge clk) rst = 1'b0;

        start[0] = 1'b1;
        abort[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            seen |= int'(tbl_rd[0]) | int'(busy[0]);
        end
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("start_abort_stays_idle", seen, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
